// File: rtl/online_otf_converter_pkg.sv
// rtl/online_otf_converter_pkg.sv - digit codes and FSM state encoding for the on-the-fly converter
package online_otf_converter_pkg;

  localparam logic [1:0] DIGIT_POS  = 2'b10;
  localparam logic [1:0] DIGIT_NEG  = 2'b01;
  localparam logic [1:0] DIGIT_ZERO = 2'b00;
  localparam logic [1:0] DIGIT_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } otfc_state_t;

endpackage

// File: rtl/otfc_digit_step.sv
// rtl/otfc_digit_step.sv - one on-the-fly conversion step: (Q, QM, d) -> (Q', QM')
module otfc_digit_step
  import online_otf_converter_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   d,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next,
  output logic         illegal
);

  // Illegal 11 digits fall into the default arm and behave as a zero digit.
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (d)
      DIGIT_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      DIGIT_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

  assign illegal = (d == DIGIT_ILL);

endmodule

// File: rtl/online_otf_converter.sv
// rtl/online_otf_converter.sv - MSD-first signed-digit to two's-complement fraction converter
module online_otf_converter
  import online_otf_converter_pkg::*;
#(
  parameter int DIGIT_NUM  = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  input  logic                  digit_valid,
  input  logic [1:0]            p_value,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DIGIT_NUM:0]    q_value,
  output logic                  q_valid,
  output logic                  digit_err
);

  localparam int W = DIGIT_NUM + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(DIGIT_NUM);

  otfc_state_t           state_q, state_d;
  logic [W-1:0]          q_q, q_d;
  logic [W-1:0]          qm_q, qm_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [W-1:0]          q_value_q, q_value_d;
  logic                  q_valid_q, q_valid_d;

  logic [W-1:0]          base_q, base_qm;
  logic [ADDR_WIDTH-1:0] base_cnt, cnt_inc;
  logic                  base_err;
  logic                  accept;
  logic [W-1:0]          step_q, step_qm;
  logic                  step_ill;

  // start re-seeds the working registers so a digit in the same cycle becomes digit 1.
  assign base_q   = start ? '0 : q_q;
  assign base_qm  = start ? '1 : qm_q;
  assign base_cnt = start ? '0 : cnt_q;
  assign base_err = start ? 1'b0 : err_q;
  assign cnt_inc  = base_cnt + 1'b1;
  assign accept   = digit_valid && (start || (state_q == ST_CONV));

  otfc_digit_step #(.W(W)) u_step (
    .q       (base_q),
    .qm      (base_qm),
    .d       (p_value),
    .q_next  (step_q),
    .qm_next (step_qm),
    .illegal (step_ill)
  );

  always_comb begin
    state_d   = state_q;
    q_d       = base_q;
    qm_d      = base_qm;
    cnt_d     = base_cnt;
    err_d     = base_err;
    q_value_d = q_value_q;
    q_valid_d = 1'b0;

    if (start) begin
      state_d = ST_CONV;
    end

    if (accept) begin
      q_d   = step_q;
      qm_d  = step_qm;
      cnt_d = cnt_inc;
      err_d = base_err | step_ill;
      if (cnt_inc == LAST_CNT) begin
        state_d   = ST_DONE;
        q_value_d = step_q;
        q_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      qm_q      <= '1;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      q_value_q <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      qm_q      <= qm_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      q_value_q <= q_value_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign busy      = (state_q == ST_CONV);
  assign rd_addr   = cnt_q;
  assign q_value   = q_value_q;
  assign q_valid   = q_valid_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_online_otf_converter.sv
// tb/tb_online_otf_converter.sv - directed self-checking bench for online_otf_converter (N=4)
module tb_online_otf_converter;

  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk;
  logic          asyn_reset;
  logic          start;
  logic          digit_valid;
  logic [1:0]    p_value;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [N:0]    q_value;
  logic          q_valid;
  logic          digit_err;

  int tests_run;
  int tests_failed;

  online_otf_converter #(.DIGIT_NUM(N), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .asyn_reset  (asyn_reset),
    .start       (start),
    .digit_valid (digit_valid),
    .p_value     (p_value),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .q_value     (q_value),
    .q_valid     (q_valid),
    .digit_err   (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [1:0] d);
    start       = 1'b0;
    digit_valid = 1'b1;
    p_value     = d;
    step();
    digit_valid = 1'b0;
    p_value     = 2'b00;
  endtask

  task automatic pulse_start();
    start       = 1'b1;
    digit_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b0;
    step();
    step();
    tests_run++;
    if ({busy, rd_addr, q_value, q_valid, digit_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b rd_addr=%0d q_value=%b q_valid=%b digit_err=%b, required all zero",
               busy, rd_addr, q_value, q_valid, digit_err);
    end
    asyn_reset = 1'b1;
    step();
    tests_run++;
    if (busy !== 1'b0 || q_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b q_valid=%b, required 0 0", busy, q_valid);
    end
  endtask

  task automatic test_basic();
    logic [1:0] seq [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
    pulse_start();
    tests_run++;
    if (busy !== 1'b1 || rd_addr !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_start: busy=%b rd_addr=%0d, required 1 0", busy, rd_addr);
    end
    for (int i = 0; i < 4; i++) begin
      send_digit(seq[i]);
      if (i < 3) begin
        tests_run++;
        if (q_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL basic_early_valid: q_valid=%b at digit %0d, required 0", q_valid, i + 1);
        end
      end
    end
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b00111 || busy !== 1'b0 || rd_addr !== 3'd4) begin
      tests_failed++;
      $display("FAIL basic_result: q_valid=%b q_value=%b busy=%b rd_addr=%0d, required 1 00111 0 4",
               q_valid, q_value, busy, rd_addr);
    end
    step();
    tests_run++;
    if (q_valid !== 1'b0 || q_value !== 5'b00111) begin
      tests_failed++;
      $display("FAIL basic_pulse_hold: q_valid=%b q_value=%b, required 0 00111", q_valid, q_value);
    end
  endtask

  task automatic test_neg_zero();
    logic [N:0] exp_q  [4] = '{5'b11111, 5'b11101, 5'b11001, 5'b10001};
    logic [N:0] exp_qm [4] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_digit(2'b01);
      tests_run++;
      if (dut.q_q !== exp_q[i] || dut.qm_q !== exp_qm[i]) begin
        tests_failed++;
        $display("FAIL neg_step%0d: Q=%b QM=%b, required %b %b", i + 1, dut.q_q, dut.qm_q, exp_q[i], exp_qm[i]);
      end
    end
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b10001) begin
      tests_failed++;
      $display("FAIL neg_result: q_valid=%b q_value=%b, required 1 10001", q_valid, q_value);
    end
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_digit(2'b00);
      tests_run++;
      if (dut.q_q !== 5'b00000 || dut.qm_q !== 5'b11111) begin
        tests_failed++;
        $display("FAIL zero_step%0d: Q=%b QM=%b, required 00000 11111", i + 1, dut.q_q, dut.qm_q);
      end
    end
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b00000) begin
      tests_failed++;
      $display("FAIL zero_result: q_valid=%b q_value=%b, required 1 00000", q_valid, q_value);
    end
  endtask

  task automatic test_start_with_digit();
    logic [1:0] seq [3] = '{2'b00, 2'b00, 2'b10};
    start       = 1'b1;
    digit_valid = 1'b1;
    p_value     = 2'b10;
    step();
    start       = 1'b0;
    digit_valid = 1'b0;
    tests_run++;
    if (rd_addr !== 3'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL swd_first: rd_addr=%0d busy=%b, required 1 1", rd_addr, busy);
    end
    for (int i = 0; i < 3; i++) begin
      send_digit(seq[i]);
      tests_run++;
      if (rd_addr !== AW'(i + 2)) begin
        tests_failed++;
        $display("FAIL swd_addr: rd_addr=%0d, required %0d", rd_addr, i + 2);
      end
    end
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b01001) begin
      tests_failed++;
      $display("FAIL swd_result: q_valid=%b q_value=%b, required 1 01001", q_valid, q_value);
    end
  endtask

  task automatic test_illegal_digit();
    pulse_start();
    send_digit(2'b10);
    tests_run++;
    if (digit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_before: digit_err=%b, required 0", digit_err);
    end
    send_digit(2'b11);
    tests_run++;
    if (digit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_flag: digit_err=%b, required 1", digit_err);
    end
    send_digit(2'b10);
    send_digit(2'b00);
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b01010 || digit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_result: q_valid=%b q_value=%b digit_err=%b, required 1 01010 1",
               q_valid, q_value, digit_err);
    end
    step();
    tests_run++;
    if (digit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_sticky: digit_err=%b, required 1", digit_err);
    end
    pulse_start();
    tests_run++;
    if (digit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_clear: digit_err=%b, required 0", digit_err);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    send_digit(2'b10);
    send_digit(2'b00);
    pulse_start();
    tests_run++;
    if (rd_addr !== 3'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_clear: rd_addr=%0d busy=%b, required 0 1", rd_addr, busy);
    end
    for (int i = 0; i < 4; i++) send_digit(2'b10);
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b01111) begin
      tests_failed++;
      $display("FAIL restart_result: q_valid=%b q_value=%b, required 1 01111", q_valid, q_value);
    end
    for (int i = 0; i < 3; i++) send_digit(2'b01);
    tests_run++;
    if (rd_addr !== 3'd4 || q_value !== 5'b01111 || q_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_ignore: rd_addr=%0d q_value=%b q_valid=%b busy=%b, required 4 01111 0 0",
               rd_addr, q_value, q_valid, busy);
    end
  endtask

  task automatic test_async_reset();
    int seen_valid;
    logic [1:0] seq [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
    pulse_start();
    send_digit(2'b10);
    send_digit(2'b10);
    #3;
    asyn_reset = 1'b0;
    #1;
    tests_run++;
    if ({busy, rd_addr, q_value, q_valid, digit_err} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b rd_addr=%0d q_value=%b q_valid=%b digit_err=%b, required all zero",
               busy, rd_addr, q_value, q_valid, digit_err);
    end
    step();
    asyn_reset = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      send_digit(2'b10);
      if (q_valid === 1'b1 || busy === 1'b1) seen_valid++;
    end
    tests_run++;
    if (seen_valid != 0) begin
      tests_failed++;
      $display("FAIL reset_abort: %0d cycles with q_valid/busy after reset, required 0", seen_valid);
    end
    pulse_start();
    for (int i = 0; i < 4; i++) send_digit(seq[i]);
    tests_run++;
    if (q_valid !== 1'b1 || q_value !== 5'b00111) begin
      tests_failed++;
      $display("FAIL reset_restart: q_valid=%b q_value=%b, required 1 00111", q_valid, q_value);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    asyn_reset   = 1'b0;
    start        = 1'b0;
    digit_valid  = 1'b0;
    p_value      = 2'b00;
    test_reset();
    test_basic();
    test_neg_zero();
    test_start_with_digit();
    test_illegal_digit();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
